sprite_mapper: RTL and testbench
================================

# sprite_mapper

Parametrised sprite pixel generator for the VGA pipeline. It replaces the fixed full-screen, single-image mappers with a positioned, integer-scaled, multi-frame animated sprite that has a transparent colour index. It drives an external synchronous sprite ROM and emits a palette index plus a hit flag. The colour-priority mux downstream composites sprites over the maze background.

## Interface
Parameters:
- SPR_W, 16, sprite width in source pixels (power of two)
- SPR_H, 16, sprite height in source pixels (power of two)
- IDX_W, 3, palette index width
- FRAMES, 4, animation frames stored back-to-back in ROM
- HOLD, 8, video frames each animation frame is shown (≥1)
- SCALE_SHIFT, 1, on-screen scale = 2^SCALE_SHIFT per axis
- TRANSP_IDX, 0, palette index treated as transparent
- ADDR_W, $clog2(FRAMES*SPR_W*SPR_H), ROM address width (derived)

Ports:
- vga_clk  in  1  pixel clock; the only clock
- reset_n  in  1  synchronous, active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  high = active video
- pos_x  in  10  requested sprite top-left X
- pos_y  in  10  requested sprite top-left Y
- enable  in  1  sprite visible; also gates animation advance
- rom_addr  out  ADDR_W  address to the sprite ROM
- rom_q  in  IDX_W  ROM data, valid 1 cycle after rom_addr
- spr_hit  out  1  current output pixel is opaque sprite
- spr_idx  out  IDX_W  palette index (0 when spr_hit=0)

## Operation
- Frame start (fs): one-cycle pulse on the first cycle where DrawX==0 && DrawY==0, after a cycle where that did not hold. It is edge-detected in a register and never repeats while the condition persists.
- Position latch: pos_x/pos_y are captured into lat_x/lat_y only on fs. All comparisons use the latched values, so no mid-frame tearing occurs.
- Box test, 11-bit unsigned arithmetic:
  - in_box = DrawX ≥ lat_x && DrawX < lat_x + (SPR_W<<SCALE_SHIFT) && DrawY ≥ lat_y && DrawY < lat_y + (SPR_H<<SCALE_SHIFT).
  - The 11-bit sum is what makes right and bottom clipping correct; the box is never wrapped.
- Texel: col = (DrawX−lat_x)>>SCALE_SHIFT, row = (DrawY−lat_y)>>SCALE_SHIFT.
- rom_addr = frame_idx*SPR_W*SPR_H + row*SPR_W + col when in_box; 0 otherwise. It is combinational from DrawX/DrawY and the latched state.
- Animation state:
  - hold_cnt ranges 0..HOLD−1. frame_idx ranges 0..FRAMES−1.
  - On fs with enable=1, hold_cnt increments. At HOLD−1 it wraps to 0 and frame_idx increments, wrapping FRAMES−1→0.
  - On fs with enable=0, both counters hold.
  - With HOLD=1 the frame advances every fs. With FRAMES=1, frame_idx stays 0.
- Output:
  - spr_hit = in_box_d & blank_d & enable_d & (rom_q ≠ TRANSP_IDX), registered.
  - spr_idx = rom_q when that hit term is 1, else 0, registered.
  - The _d terms are delayed one cycle to align with rom_q.
- Reset (reset_n=0 at a clock edge):
  - lat_x, lat_y, hold_cnt, frame_idx, the fs edge register, the pipeline flops, spr_hit and spr_idx all go to 0.
  - Reset asserted mid-frame: positions return to (0,0), and the next fs re-latches them.

## Timing
- Latency is 2 cycles from DrawX/DrawY to spr_hit/spr_idx.
  - Cycle N: inputs present, rom_addr driven.
  - Cycle N+1: rom_q valid; in_box, blank and enable delayed.
  - Cycle N+2: outputs registered.
- A pos change takes effect on the fs after the change. The first sprite pixel appears 2 cycles after DrawX==lat_x on row lat_y.
- frame_idx changes in the cycle after fs, so the whole video frame uses one animation frame.
- If enable falls mid-frame, spr_hit is 0 from 2 cycles later. Counters freeze from the next fs.
- blank low forces spr_hit=0 regardless of the ROM contents.

## Configuration
- SPRITE_MIRROR_EN defined: adds input mirror_x (1 bit), latched on fs with the position. When the latched value is 1, col is replaced by SPR_W−1−col before address formation.
- SPRITE_MIRROR_EN undefined: no mirror_x port and no mirror logic; col is used unmodified.

## Structure
- Shared package sprite_pkg: SCREEN_W=640, SCREEN_H=480, the coord_t (10-bit) typedef, and the frame-start detect helper function.
- Sub-module sprite_anim_ctr: fs edge detect plus the hold_cnt/frame_idx counters, parametrised by HOLD and FRAMES. The position/box/pipeline logic stays in sprite_mapper.
- The ROM and palette are external. Per-sprite *_rom/*_palette pairs connect directly.

## Test plan
- Defaults, pos=(100,50), ROM texel (0,0)=5: DrawX=100, DrawY=50 → spr_hit=1, spr_idx=5 two cycles later. DrawX=99 → spr_hit=0.
- Scale: DrawX=131, DrawY=81 → rom_addr selects col 15, row 15. DrawX=132 → spr_hit=0, a clipped edge.
- Right clip, pos_x=630: DrawX 630..639 hit; no wrap to DrawX 0..21 on the next line.
- Animation, HOLD=2, FRAMES=4: after 8 fs pulses, frame_idx sequence is 0,0,1,1,2,2,3,3 then 0. With enable=0 the counters hold.
- Transparency and blank: texel equals TRANSP_IDX → spr_hit=0, spr_idx=0. blank=0 over an opaque texel → spr_hit=0.
- Reset mid-frame at frame_idx=2, lat=(100,50) → next cycle all outputs 0 and frame_idx=0. pos is re-latched on the next fs.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared VGA sprite types: screen geometry, pixel coordinate type, frame-start helper.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  function automatic logic at_origin(coord_t x, coord_t y);
    return (x == 10'd0) && (y == 10'd0);
  endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Frame-start edge detect plus hold/frame animation counters for one sprite.
module sprite_anim_ctr
  import sprite_pkg::*;
#(
  parameter int unsigned HOLD   = 8,
  parameter int unsigned FRAMES = 4,
  parameter int unsigned FW     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  coord_t        DrawX,
  input  coord_t        DrawY,
  input  logic          enable,
  output logic          fs,
  output logic [FW-1:0] frame_idx
);

  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic          org_q;
  logic [HW-1:0] hold_q;
  logic [FW-1:0] frame_q;

  // Pulse only on entry to the origin so a held (0,0) cannot retrigger.
  assign fs        = at_origin(DrawX, DrawY) && !org_q;
  assign frame_idx = frame_q;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      org_q   <= 1'b0;
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      org_q <= at_origin(DrawX, DrawY);
      if (fs && enable) begin
        if (hold_q == HW'(HOLD - 1)) begin
          hold_q  <= '0;
          frame_q <= (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + FW'(1);
        end else begin
          hold_q <= hold_q + HW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sprite_mapper.sv
// Positioned, integer-scaled, animated sprite pixel generator driving an external sync ROM.
// Optional horizontal mirroring is built when SPRITE_MIRROR_EN is defined.
module sprite_mapper
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W       = 16,
  parameter int unsigned SPR_H       = 16,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned FRAMES      = 4,
  parameter int unsigned HOLD        = 8,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned TRANSP_IDX  = 0,
  parameter int unsigned ADDR_W      = $clog2(FRAMES * SPR_W * SPR_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  coord_t            DrawX,
  input  coord_t            DrawY,
  input  logic              blank,
  input  coord_t            pos_x,
  input  coord_t            pos_y,
  input  logic              enable,
`ifdef SPRITE_MIRROR_EN
  input  logic              mirror_x,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              spr_hit,
  output logic [IDX_W-1:0]  spr_idx
);

  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned CW = $clog2(SPR_W);
  localparam int unsigned RW = $clog2(SPR_H);
  localparam logic [10:0] BOX_W = 11'(SPR_W << SCALE_SHIFT);
  localparam logic [10:0] BOX_H = 11'(SPR_H << SCALE_SHIFT);

  logic          fs;
  logic [FW-1:0] frame_idx;
  coord_t        lat_x_q, lat_y_q;
  logic [10:0]   x_end, y_end;
  logic          in_box, in_box_q, blank_q, enable_q, hit;
  logic [CW-1:0] col, col_eff;
  logic [RW-1:0] row;
  logic             spr_hit_q;
  logic [IDX_W-1:0] spr_idx_q;

  sprite_anim_ctr #(
    .HOLD   (HOLD),
    .FRAMES (FRAMES),
    .FW     (FW)
  ) u_anim (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .enable    (enable),
    .fs        (fs),
    .frame_idx (frame_idx)
  );

`ifdef SPRITE_MIRROR_EN
  logic mirror_q;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      mirror_q <= 1'b0;
    end else if (fs) begin
      mirror_q <= mirror_x;
    end
  end

  assign col_eff = mirror_q ? CW'(SPR_W - 1) - col : col;
`else
  assign col_eff = col;
`endif

  // 11-bit end coordinates so a box near the right/bottom edge clips instead of wrapping.
  always_comb begin
    x_end  = {1'b0, lat_x_q} + BOX_W;
    y_end  = {1'b0, lat_y_q} + BOX_H;
    in_box = (DrawX >= lat_x_q) && ({1'b0, DrawX} < x_end) &&
             (DrawY >= lat_y_q) && ({1'b0, DrawY} < y_end);
    col    = CW'((DrawX - lat_x_q) >> SCALE_SHIFT);
    row    = RW'((DrawY - lat_y_q) >> SCALE_SHIFT);
    rom_addr = '0;
    if (in_box) begin
      rom_addr = ADDR_W'(frame_idx) * ADDR_W'(SPR_W * SPR_H) +
                 ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col_eff);
    end
  end

  assign hit = in_box_q & blank_q & enable_q & (rom_q != IDX_W'(TRANSP_IDX));

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      lat_x_q   <= '0;
      lat_y_q   <= '0;
      in_box_q  <= 1'b0;
      blank_q   <= 1'b0;
      enable_q  <= 1'b0;
      spr_hit_q <= 1'b0;
      spr_idx_q <= '0;
    end else begin
      if (fs) begin
        lat_x_q <= pos_x;
        lat_y_q <= pos_y;
      end
      in_box_q  <= in_box;
      blank_q   <= blank;
      enable_q  <= enable;
      spr_hit_q <= hit;
      spr_idx_q <= hit ? rom_q : '0;
    end
  end

  assign spr_hit = spr_hit_q;
  assign spr_idx = spr_idx_q;

endmodule

// File: tb/tb_sprite_mapper.sv
// Randomized bench for sprite_mapper against a per-pixel reference model with a modelled ROM.
module tb_sprite_mapper;

  localparam int SW   = 16;
  localparam int SH   = 16;
  localparam int IW   = 3;
  localparam int NF   = 4;
  localparam int HD   = 2;
  localparam int SS   = 1;
  localparam int TI   = 0;
  localparam int AW   = 10;
  localparam int BOXW = SW << SS;
  localparam int BOXH = SH << SS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [9:0]    DrawX, DrawY, pos_x, pos_y;
  logic          blank, enable;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_q;
  logic          spr_hit;
  logic [IW-1:0] spr_idx;

  logic [IW-1:0] rom_mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: latched position, count of enabled frame starts, output pipeline.
  int m_lx, m_ly, m_adv, m_prev_org;
  int stb_hit, stb_idx, out_hit, out_idx;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  sprite_mapper #(
    .SPR_W       (SW),
    .SPR_H       (SH),
    .IDX_W       (IW),
    .FRAMES      (NF),
    .HOLD        (HD),
    .SCALE_SHIFT (SS),
    .TRANSP_IDX  (TI)
  ) dut (
    .vga_clk  (clk),
    .reset_n  (reset_n),
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .blank    (blank),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .enable   (enable),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .spr_hit  (spr_hit),
    .spr_idx  (spr_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Texel address for a screen pixel, or -1 outside the sprite box.
  function automatic int ref_addr(int x, int y);
    int frame;
    if (x < m_lx || x >= m_lx + BOXW || y < m_ly || y >= m_ly + BOXH) return -1;
    frame = (m_adv / HD) % NF;
    return frame * SW * SH + ((y - m_ly) / (1 << SS)) * SW + (x - m_lx) / (1 << SS);
  endfunction

  task automatic cyc();
    int a, ha, ia, org;
    #1;
    a = ref_addr(int'(DrawX), int'(DrawY));
    check_eq("rom_addr", 32'(rom_addr), (a < 0) ? 0 : a);
    ha = 0;
    ia = 0;
    if (a >= 0 && blank && enable && int'(rom_mem[a]) != TI) begin
      ha = 1;
      ia = int'(rom_mem[a]);
    end
    @(posedge clk);
    if (!reset_n) begin
      out_hit = 0; out_idx = 0; stb_hit = 0; stb_idx = 0;
      m_lx = 0; m_ly = 0; m_adv = 0; m_prev_org = 0;
    end else begin
      out_hit = stb_hit; out_idx = stb_idx;
      stb_hit = ha;      stb_idx = ia;
      org = (DrawX == 0 && DrawY == 0) ? 1 : 0;
      if (org == 1 && m_prev_org == 0) begin
        m_lx = int'(pos_x);
        m_ly = int'(pos_y);
        if (enable) m_adv++;
      end
      m_prev_org = org;
    end
    #1;
    check_eq("spr_hit", 32'(spr_hit), out_hit);
    check_eq("spr_idx", 32'(spr_idx), out_idx);
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    cyc();
  endtask

  task automatic new_frame(input int px, input int py);
    pix(1, 1);
    pos_x = 10'(px);
    pos_y = 10'(py);
    pix(0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = IW'($urandom_range(0, 7));
    for (int f = 0; f < NF; f++) begin
      rom_mem[f*SW*SH]         = 3'd5;
      rom_mem[f*SW*SH + 1]     = 3'd0;
      rom_mem[f*SW*SH + 255]   = 3'd6;
    end
    reset_n = 1'b0; blank = 1'b1; enable = 1'b1;
    DrawX = 10'd300; DrawY = 10'd300; pos_x = '0; pos_y = '0;
    repeat (3) @(posedge clk);
    #1;
    m_lx = 0; m_ly = 0; m_adv = 0; m_prev_org = 0;
    stb_hit = 0; stb_idx = 0; out_hit = 0; out_idx = 0;
    check_eq("rst_hit", 32'(spr_hit), 0);
    check_eq("rst_idx", 32'(spr_idx), 0);
    check_eq("rst_addr", 32'(rom_addr), 0);
    reset_n = 1'b1;

    // Top-left texel, left miss, scaled bottom-right corner, clipped edge.
    new_frame(100, 50);
    pix(100, 50);
    pix(99, 50);
    check_eq("tl_hit", 32'(spr_hit), 1);
    check_eq("tl_idx", 32'(spr_idx), 5);
    pix(131, 81);
    check_eq("left_miss", 32'(spr_hit), 0);
    pix(132, 81);
    check_eq("br_idx", 32'(spr_idx), 6);
    pix(102, 50);
    blank = 1'b0;
    pix(100, 50);
    blank = 1'b1;
    pix(131, 82);
    pix(5, 5);
    check_eq("blank_hit", 32'(spr_hit), 0);

    // Right clip without wrap onto the next line.
    new_frame(630, 50);
    for (int x = 620; x < 640; x++) pix(x, 50);
    for (int x = 0; x < 26; x++) pix(x, 51);

    // Animation stepping with a stretch of disabled frames.
    for (int f = 0; f < 10; f++) begin
      enable = (f == 6 || f == 7) ? 1'b0 : 1'b1;
      new_frame(100, 50);
      for (int k = 0; k < 6; k++) pix(100 + $urandom_range(0, 31), 50 + $urandom_range(0, 31));
    end
    enable = 1'b1;

    // Reset mid-frame, then re-latch on the next frame start.
    new_frame(100, 50);
    pix(110, 60);
    pix(111, 61);
    reset_n = 1'b0;
    pix(112, 62);
    reset_n = 1'b1;
    check_eq("rst_mid_hit", 32'(spr_hit), 0);
    check_eq("rst_mid_idx", 32'(spr_idx), 0);
    pix(100, 50);
    pix(101, 51);
    new_frame(100, 50);
    pix(100, 50);
    pix(101, 50);

    // Random frames: positions incl. screen edges, held origin, random blank/enable/reset.
    for (int f = 0; f < 60; f++) begin
      int px, py, hold;
      px = (f % 7 == 0) ? 620 + $urandom_range(0, 19) : $urandom_range(0, 639);
      py = (f % 5 == 0) ? 460 + $urandom_range(0, 19) : $urandom_range(0, 479);
      enable = ($urandom_range(0, 4) != 0);
      new_frame(px, py);
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) pix(0, 0);
      for (int k = 0; k < 50; k++) begin
        blank   = ($urandom_range(0, 9) != 0);
        reset_n = ($urandom_range(0, 199) != 0);
        if ($urandom_range(0, 15) == 0) enable = ~enable;
        pix((m_lx + $urandom_range(0, BOXW + 8) + 1020) % 1024,
            (m_ly + $urandom_range(0, BOXH + 8) + 1020) % 1024);
        reset_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
